// File: rtl/axi_inf_write_slave_core.sv
// AXI4 write-channel responder: one AW burst at a time, W beats forwarded to a
// local store port with back-pressure, one B response per burst. Illegal size,
// unsupported burst type or bad WLAST framing is answered with SLVERR.
module axi_inf_write_slave_core #(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 10,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic                 wr_en,
  output logic [ASIZE-1:0]     wr_addr,
  output logic [DSIZE-1:0]     wr_data,
  output logic [DSIZE/8-1:0]   wr_strb,
  input  logic                 wr_ready,
  output logic                 burst_done,
  output logic                 burst_err
);

  localparam int               BPB       = DSIZE / 8;
  localparam logic [2:0]       SIZE_CODE = 3'($clog2(BPB));
  localparam logic [ASIZE-1:0] ADDR_INC  = ASIZE'(BPB);
  localparam logic [LSIZE:0]   BCNT_ONE  = (LSIZE+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDSIZE-1:0]  id_q, id_d;
  logic [ASIZE-1:0]   addr_q, addr_d;
  logic [LSIZE-1:0]   len_q, len_d;
  logic               incr_q, incr_d;
  logic [LSIZE:0]     bcnt_q, bcnt_d;
  logic               err_q, err_d;

  logic [LSIZE:0]     len_ext;
  logic               aw_hs, beat_acc, b_hs, in_range;

  assign len_ext  = {1'b0, len_q};
  assign in_range = (bcnt_q <= len_ext);

  // Handshake outputs are forced low while reset is held.
  assign axi_awready = ~axi_reset & (state_q == S_IDLE);
  assign axi_wready  = ~axi_reset & (state_q == S_DATA) & wr_ready;
  assign axi_bvalid  = ~axi_reset & (state_q == S_RESP);

  assign aw_hs    = axi_awvalid & axi_awready;
  assign beat_acc = axi_wvalid & axi_wready;
  assign b_hs     = axi_bvalid & axi_bready;

  // Store port: a beat is written only while the burst is clean and in range.
  assign wr_en   = beat_acc & ~err_q & in_range;
  assign wr_addr = addr_q;
  assign wr_data = axi_wdata;
  assign wr_strb = axi_wstrb;

  assign axi_bid    = id_q;
  assign axi_bresp  = err_q ? 2'b10 : 2'b00;
  assign burst_done = b_hs;
  assign burst_err  = b_hs & err_q;

  // Next-state: AW capture, beat counting/addressing, framing checks, B hand-off.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    incr_d  = incr_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = axi_awid;
          addr_d  = axi_awaddr;
          len_d   = axi_awlen;
          incr_d  = (axi_awburst == 2'b01);
          bcnt_d  = '0;
          err_d   = (axi_awsize != SIZE_CODE) | axi_awburst[1];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_acc) begin
          if (incr_q) addr_d = addr_q + ADDR_INC;
          // Counter stops one past the last legal beat; overrun beats only need "out of range".
          if (in_range) bcnt_d = bcnt_q + BCNT_ONE;
          if (axi_wlast) begin
            if (bcnt_q != len_ext) err_d = 1'b1;
            state_d = S_RESP;
          end else if (bcnt_q >= len_ext) begin
            err_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and burst-context registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      incr_q  <= 1'b0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      incr_q  <= incr_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

endmodule
